// File: rtl/reaction_controller.sv
// reaction_controller -- reaction-time game sequencer.
//
// Waits a random (floored) number of 1 ms ticks after Start, lights the LED,
// then counts ticks until the player presses React. The finished count is
// offered to two external register rows: the last-result row (Load) and the
// best-time row (BestLoad, only when the new time beats the stored best).
//
// Ports
//   Clock    : rising-edge clock
//   CLRN     : asynchronous active-low reset
//   Start    : one-cycle start pulse (honoured in IDLE/DONE/FOUL)
//   React    : one-cycle player press (honoured in WAIT/GO)
//   Tick     : one-cycle 1 ms timebase enable
//   DelayIn  : random wait length in ticks, sampled on Start
//   BestQ    : current contents of the best-time register row
//   Count    : reaction count, feeds both register rows
//   Load     : one-cycle strobe for the last-result row
//   BestLoad : one-cycle strobe for the best-time row
//   Led      : go-light
//   Early    : false start flag
//   Timeout  : player never reacted flag
module reaction_controller #(
  parameter logic [12:0] MIN_DELAY = 13'd500,
  parameter logic [12:0] MAX_COUNT = 13'd8191
) (
  input  logic        Clock,
  input  logic        CLRN,
  input  logic        Start,
  input  logic        React,
  input  logic        Tick,
  input  logic [12:0] DelayIn,
  input  logic [12:0] BestQ,
  output logic [12:0] Count,
  output logic        Load,
  output logic        BestLoad,
  output logic        Led,
  output logic        Early,
  output logic        Timeout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    GO   = 3'd2,
    DONE = 3'd3,
    FOUL = 3'd4
  } state_t;

  state_t      state_q;
  logic [12:0] count_q;
  logic [12:0] delay_q;
  logic        led_q;
  logic        early_q;
  logic        timeout_q;
  logic        load_q;
  logic        best_valid_q;
  logic [12:0] delay_ld_d;

  // Floor the requested delay so the wait can never be trivially short.
  assign delay_ld_d = (DelayIn > MIN_DELAY) ? DelayIn : MIN_DELAY;

  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state_q      <= IDLE;
      count_q      <= 13'd0;
      delay_q      <= 13'd0;
      led_q        <= 1'b0;
      early_q      <= 1'b0;
      timeout_q    <= 1'b0;
      load_q       <= 1'b0;
      best_valid_q <= 1'b0;
    end else begin
      // Load is a single-cycle pulse in the first DONE cycle.
      load_q <= 1'b0;
      if (BestLoad) best_valid_q <= 1'b1;
      case (state_q)
        IDLE, DONE, FOUL: begin
          if (Start) begin
            state_q   <= WAIT;
            delay_q   <= delay_ld_d;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= 13'd0;
            led_q     <= 1'b0;
          end
        end
        WAIT: begin
          // A press beats a simultaneous final tick.
          if (React) begin
            state_q <= FOUL;
            early_q <= 1'b0 | 1'b1;
            delay_q <= 13'd0;
          end else if (Tick) begin
            // <= 1 also covers a zero floor with a zero delay.
            if (delay_q <= 13'd1) begin
              state_q <= GO;
              delay_q <= 13'd0;
              led_q   <= 1'b1;
              count_q <= 13'd0;
            end else begin
              delay_q <= delay_q - 13'd1;
            end
          end
        end
        GO: begin
          // A press captures the pre-tick count.
          if (React) begin
            state_q <= DONE;
            led_q   <= 1'b0;
            load_q  <= 1'b1;
          end else if (Tick) begin
            if (count_q >= MAX_COUNT - 13'd1) begin
              state_q   <= DONE;
              count_q   <= MAX_COUNT;
              timeout_q <= 1'b1;
              led_q     <= 1'b0;
              load_q    <= 1'b1;
            end else begin
              count_q <= count_q + 13'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Best row is refreshed only by a strictly better, non-timeout result;
  // the first valid result after reset always wins.
  assign BestLoad = load_q & ~timeout_q & (~best_valid_q | (count_q < BestQ));

  assign Count   = count_q;
  assign Load    = load_q;
  assign Led     = led_q;
  assign Early   = early_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_reaction_controller.sv
module tb_reaction_controller;

  localparam int MIN  = 500;
  localparam int MAXC = 8191;

  logic        Clock = 1'b0;
  logic        CLRN = 1'b0;
  logic        Start = 1'b0, React = 1'b0, Tick = 1'b0;
  logic [12:0] DelayIn = 13'd0;
  logic [12:0] BestQ;
  logic [12:0] Count;
  logic        Load, BestLoad, Led, Early, Timeout;

  logic [12:0] best_reg = 13'd0;
  assign BestQ = best_reg;

  reaction_controller dut (
    .Clock(Clock), .CLRN(CLRN), .Start(Start), .React(React), .Tick(Tick),
    .DelayIn(DelayIn), .BestQ(BestQ), .Count(Count), .Load(Load),
    .BestLoad(BestLoad), .Led(Led), .Early(Early), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  // External best-time register row.
  always_ff @(posedge Clock) if (BestLoad) best_reg <= Count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    int bl;
    int to;
  } exp_t;
  exp_t exp_q[$];

  // Reference model of the best-time bookkeeping.
  bit m_valid = 1'b0;
  int m_best  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void predict(input int r, input bit timed_out);
    exp_t e;
    if (timed_out) begin
      e.cnt = MAXC; e.bl = 0; e.to = 1;
    end else begin
      e.cnt = r; e.to = 0;
      e.bl = (!m_valid || r < m_best) ? 1 : 0;
      if (e.bl == 1) begin
        m_best  = r;
        m_valid = 1'b1;
      end
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: every Load pulse must match the oldest predicted result.
  initial begin
    bit prev_load = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clock);
      if (CLRN) begin
        if (BestLoad && !Load) chk("bestload_without_load", 1, 0);
        if (Load) begin
          if (prev_load) chk("load_width", 2, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_load", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("load_count", int'(Count), e.cnt);
            chk("load_bestload", int'(BestLoad), e.bl);
            chk("load_timeout", int'(Timeout), e.to);
            chk("load_led", int'(Led), 0);
          end
        end
        prev_load = Load;
      end else begin
        prev_load = 1'b0;
      end
    end
  end

  task automatic cyc(input bit s, input bit r, input bit t);
    Start = s; React = r; Tick = t;
    @(posedge Clock); #1;
    Start = 1'b0; React = 1'b0; Tick = 1'b0;
  endtask

  task automatic tick_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) cyc(0, 0, 0);
      cyc(0, 0, 1);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_count"}, int'(Count), 0);
    chk({nm, "_led"}, int'(Led), 0);
    chk({nm, "_load"}, int'(Load), 0);
    chk({nm, "_bestload"}, int'(BestLoad), 0);
    chk({nm, "_early"}, int'(Early), 0);
    chk({nm, "_timeout"}, int'(Timeout), 0);
  endtask

  // mode 0: react after r GO ticks; 1: never react (timeout); 2: reset after r GO ticks
  task automatic round(input int dly, input int mode, input int r, input bit wt, input int gap);
    int eff;
    eff = (dly > MIN) ? dly : MIN;
    DelayIn = 13'(dly);
    cyc(1, 0, 0);
    chk("start_early", int'(Early), 0);
    chk("start_timeout", int'(Timeout), 0);
    chk("start_count", int'(Count), 0);
    tick_n(1, gap);
    DelayIn = 13'd1;
    cyc(1, 0, 0);                  // Start in WAIT must not reload
    tick_n(eff - 2, gap);
    chk("led_wait", int'(Led), 0);
    tick_n(1, gap);
    chk("led_go", int'(Led), 1);
    chk("count_go", int'(Count), 0);
    if (mode == 1) begin
      predict(0, 1'b1);
      tick_n(MAXC, 0);
      chk("to_count", int'(Count), MAXC);
      chk("to_flag", int'(Timeout), 1);
      chk("to_led", int'(Led), 0);
      cyc(0, 1, 1);
      chk("to_hold", int'(Count), MAXC);
    end else begin
      tick_n(r, gap);
      chk("go_count", int'(Count), r);
      cyc(1, 0, 0);                // Start in GO ignored
      chk("go_start_ign", int'(Led), 1);
      if (mode == 2) begin
        @(posedge Clock); #3;
        CLRN = 1'b0;
        #1 chk_all_zero("abort");
        React = 1'b1;
        @(posedge Clock); #1;
        React = 1'b0;
        chk_all_zero("abort_held");
        #2 CLRN = 1'b1;
        m_valid = 1'b0;
        @(posedge Clock); #1;
      end else begin
        predict(r, 1'b0);
        cyc(0, 1, wt);
        chk("done_led", int'(Led), 0);
        chk("done_count", int'(Count), r);
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        chk("done_hold", int'(Count), r);
      end
    end
  endtask

  task automatic foul(input int dly, input int w, input bit wt, input int gap);
    DelayIn = 13'(dly);
    cyc(1, 0, 0);
    chk("foul_start_early", int'(Early), 0);
    tick_n(w, gap);
    cyc(0, 1, wt);
    chk("foul_early", int'(Early), 1);
    chk("foul_led", int'(Led), 0);
    chk("foul_count", int'(Count), 0);
    cyc(0, 1, 1);
    chk("foul_hold", int'(Early), 1);
  endtask

  initial begin
    int eff, dly, mode;
    #2 chk_all_zero("reset");
    #10 CLRN = 1'b1;
    @(posedge Clock); #1;
    cyc(0, 1, 1);                  // React in IDLE ignored
    chk_all_zero("idle_react");

    round(3, 2, 10, 1'b0, 0);      // floor to 500, then reset mid-GO
    round(600, 0, 250, 1'b0, 0);   // first result -> best
    round(700, 0, 300, 1'b0, 1);   // slower -> no best
    round(0, 0, 120, 1'b0, 1);     // faster -> best
    round(510, 0, 120, 1'b0, 0);   // equal -> no best
    foul(700, 10, 1'b0, 0);
    foul(0, MIN - 1, 1'b1, 0);     // React with the final WAIT tick
    round(0, 0, 42, 1'b1, 0);      // React with Tick captures 42
    round(0, 1, 0, 1'b0, 0);       // timeout

    for (int k = 0; k < 8; k++) begin
      dly  = int'($urandom_range(0, 900));
      mode = int'($urandom_range(0, 3));
      eff  = (dly > MIN) ? dly : MIN;
      if (mode == 0)
        foul(dly, int'($urandom_range(0, eff - 1)), 1'($urandom_range(0, 1)), 1);
      else
        round(dly, 0, int'($urandom_range(0, 600)), 1'($urandom_range(0, 1)), 2);
    end

    repeat (5) cyc(0, 0, 0);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
